// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for the EX stage (DIV / DIVU).
//   It uses restoring division with one quotient bit per cycle. The result is
//   written as {hi_o, lo_o} = {remainder, quotient}.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   start_i      EX holds a DIV/DIVU (held high while the instruction sits in EX)
//   signed_i     1 = DIV (signed), 0 = DIVU
//   opdata1_i    dividend (rs)
//   opdata2_i    divisor  (rt)
//   annul_i      exception flush: abort, back to IDLE, result not written
//   hold_i       inst/data memory stall: keep the result stable in END
//   hi_o         remainder
//   lo_o         quotient
//   ready_o      hi_o/lo_o hold a fresh result (state END)
//   ex_ok_o      to the stall controller; 0 stalls the whole pipeline
//   dbg_state_o  current FSM state (IDLE=0, BY_ZERO=1, ON=2, END=3)
//
// Handshake: a request is start_i=1 seen in IDLE with annul_i=0. The operands
// are sampled on that cycle only. From that cycle until the one before END,
// ex_ok_o is 0. In END, ready_o=1 and ex_ok_o=1. The result is consumed on the
// first edge with hold_i=0, and the FSM returns to IDLE on that same edge.
// annul_i overrides everything: ex_ok_o goes to 1 at once and the next state
// is IDLE.
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              annul_i,
    input  logic              hold_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              ready_o,
    output logic              ex_ok_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;    // partial remainder
    logic [DATA_W-1:0] quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] dvsr_q, dvsr_d;  // |divisor|
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              sgn_q, sgn_d;    // operation is signed
    logic              neg1_q, neg1_d;  // dividend negative (signed only)
    logic              neg2_q, neg2_d;  // divisor negative (signed only)
    logic              ex_ok;

    // Operand magnitudes. The magnitude of the most negative value wraps to
    // itself, and that is correct once it is read as unsigned.
    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] abs1, abs2;

    always_comb begin
        op1_neg = signed_i & opdata1_i[DATA_W-1];
        op2_neg = signed_i & opdata2_i[DATA_W-1];
        abs1    = op1_neg ? -opdata1_i : opdata1_i;
        abs2    = op2_neg ? -opdata2_i : opdata2_i;
    end

    // One restoring step. Shift {rem, quo} left by one, then trial-subtract.
    // The shifted remainder is DATA_W+1 bits wide, so the compare sees its
    // carry-out. When the subtraction succeeds the difference is below the
    // divisor, so its low DATA_W bits are exact.
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              step_ge;
    logic [DATA_W-1:0] step_rem, step_quo;
    logic [DATA_W-1:0] rem_fix, quo_fix;

    always_comb begin
        shifted  = {rem_q, quo_q[DATA_W-1]};
        diff     = shifted[DATA_W-1:0] - dvsr_q;
        step_ge  = (shifted >= {1'b0, dvsr_q});
        step_rem = step_ge ? diff : shifted[DATA_W-1:0];
        step_quo = {quo_q[DATA_W-2:0], step_ge};
        // Sign fix applied on the final step: quotient takes the XOR of the
        // operand signs, remainder takes the sign of the dividend.
        quo_fix  = (sgn_q & (neg1_q ^ neg2_q)) ? -step_quo : step_quo;
        rem_fix  = (sgn_q & neg1_q) ? -step_rem : step_rem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        ex_ok   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    ex_ok  = 1'b0;
                    sgn_d  = signed_i;
                    neg1_d = op1_neg;
                    neg2_d = op2_neg;
                    if (opdata2_i == '0) begin
                        state_d = S_BY_ZERO;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs1;
                        dvsr_d  = abs2;
                        cnt_d   = '0;
                        state_d = S_ON;
                    end
                end
            end
            S_BY_ZERO: begin
                // The result is architecturally undefined; it is pinned to zero.
                ex_ok   = 1'b0;
                hi_d    = '0;
                lo_d    = '0;
                state_d = S_END;
            end
            S_ON: begin
                ex_ok = 1'b0;
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = S_END;
                end
            end
            S_END: begin
                // The pipeline advances on the same edge that leaves END, so
                // start_i seen next cycle belongs to a new instruction.
                if (!hold_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush wins over start and hold. Nothing reaches the result registers.
        if (annul_i) begin
            state_d = S_IDLE;
            ex_ok   = 1'b1;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
        end
    end

    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign ready_o     = (state_q == S_END);
    assign ex_ok_o     = ex_ok;
    assign dbg_state_o = state_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; executes DIV/DIVU.
- Writes {remainder, quotient} as {HI, LO}.
- Produces the ex_ok handshake the pipeline stall/flush controller consumes: low while a divide is in flight, which stalls every pipeline stage.
- Honours the controller's flush and external (inst/data) stall back toward itself.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  EX instruction is DIV/DIVU; held high by the pipeline while the instruction sits in EX.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend (rs).
- opdata2_i  in  DATA_W  divisor (rt).
- annul_i  in  1  exception flush; abort the current operation.
- hold_i  in  1  pipeline stalled by an inst/data memory stall; result must be held.
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.
- ready_o  out  1  hi_o/lo_o valid.
- ex_ok_o  out  1  to the stall controller; 0 stalls the whole pipeline.

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, counter=0, internal regs=0.
  - hi_o=0, lo_o=0, ready_o=0.
  - ex_ok_o=1 unless start_i is high.
  - Reset mid-operation aborts without any result.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - If start_i=1 and annul_i=0: latch signed_i and operand signs.
  - Divisor==0 -> go to BY_ZERO.
  - Otherwise load |dividend| and |divisor| (absolute value only when signed_i=1), clear counter, go to ON.
  - |0x80000000| is 0x80000000, treated as unsigned.
- ON:
  - One restoring-division step per cycle: shift {partial remainder, dividend} left 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Counter increments each step. After DATA_W steps (counter==DATA_W-1 at the edge), go to END.
- ON -> END sign fix (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - Result is registered into hi_o/lo_o.
- BY_ZERO: one cycle, then END with hi_o=0, lo_o=0 (architecturally undefined; fixed to 0).
- END:
  - ready_o=1, ex_ok_o=1.
  - Stay in END while hold_i=1 (outputs stable).
  - When hold_i=0, go to IDLE on the next edge. The pipeline advances on that same edge, so the instruction leaves EX and cannot restart.
  - ready_o clears in IDLE; hi_o/lo_o keep their value until the next END.
- ex_ok_o (combinational):
  - 0 when (state==IDLE and start_i=1 and annul_i=0), or state is ON or BY_ZERO.
  - Otherwise 1.
- Latency: issue cycle is C0 (IDLE).
  - Normal divide: ON during C1..C32, END at C33; ex_ok_o=0 during C0..C32.
  - Divide by zero: END at C2.
- annul_i=1 in any state:
  - Next state IDLE, ex_ok_o=1 in the same cycle, ready_o=0 next cycle.
  - hi_o/lo_o are not updated.
  - annul_i has priority over start_i and hold_i.
- hold_i during ON/BY_ZERO has no effect; iteration continues.
- Operands are sampled only in IDLE; later changes to the operand inputs are ignored until return to IDLE.

Test Plan:
- Unsigned divide: DIVU 100/7 -> ex_ok_o low C0..C32; END at C33 with lo_o=14 (0x0E), hi_o=2, ready_o=1; IDLE at C34.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Overflow case 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Divide by zero: DIV 5/0 -> BY_ZERO at C1, END at C2 with hi_o=lo_o=0, ex_ok_o=1 at C2.
- Annul mid-operation: annul_i=1 at C10 -> ex_ok_o=1 that cycle, IDLE at C11. Previous hi_o/lo_o unchanged. A new DIVU 9/3 then yields lo_o=3, hi_o=0.
- Hold in END: hold_i=1 for 3 cycles from C33 -> state END and ready_o=1 held, hi_o/lo_o stable; IDLE one cycle after hold_i drops.
- Async reset at C15 of a divide: outputs go to 0 immediately, state IDLE. After reset release, a new DIVU 0xFFFFFFFF/0x10 gives lo_o=0x0FFFFFFF, hi_o=0xF.
